// File: rtl/enc_hamming_pipe.sv
// Two-stage extended-Hamming encoder (8/16/32-bit codewords) with valid/ready flow control,
// illegal-mode flagging and a wrapping count of delivered codewords.
module enc_hamming_pipe #(
    parameter int AMBA_WORD          = 32,
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     data_in,
    input  logic [AMBA_WORD-1:0]          work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic                          mode_err,
    output logic [CNT_WIDTH-1:0]          cw_count
);

    localparam logic MODE1_OK = (MAX_CODEWORD_WIDTH >= 32'sd16);
    localparam logic MODE2_OK = (MAX_CODEWORD_WIDTH >= 32'sd32);

    // Hamming bits j=0..4 over positions 3,5,6,7,9,... (integers >=3 that are not powers of two).
    // Info is pre-masked to K bits, so bits above P-2 come out zero for the narrow modes.
    function automatic logic [4:0] ham_bits(input logic [25:0] info);
        logic [4:0] h;
        logic [4:0] idx;
        h   = 5'd0;
        idx = 5'd0;
        for (logic [5:0] pos = 6'd3; pos < 6'd32; pos = pos + 6'd1) begin
            if ((pos & (pos - 6'd1)) != 6'd0) begin
                for (logic [2:0] j = 3'd0; j < 3'd5; j = j + 3'd1) begin
                    if (pos[j]) begin
                        h[j] = h[j] ^ info[idx];
                    end
                end
                idx = idx + 5'd1;
            end
        end
        return h;
    endfunction

    function automatic logic [25:0] info_mask(input logic [1:0] mode);
        logic [25:0] m;
        case (mode)
            2'd0:    m = 26'h000_000F;
            2'd1:    m = 26'h000_07FF;
            2'd2:    m = 26'h3FF_FFFF;
            default: m = 26'h000_0000;
        endcase
        return m;
    endfunction

    logic        s1_valid_r;
    logic [25:0] s1_info_r;
    logic [1:0]  s1_mode_r;
    logic        s1_legal_r;
    logic [4:0]  s1_ham_r;
    logic        s1_ovp_r;
    logic        s2_valid_r;
    logic [MAX_CODEWORD_WIDTH-1:0] data_out_r;
    logic        mode_err_r;
    logic [CNT_WIDTH-1:0] cw_count_r;

    logic        s2_ready_s;
    logic        in_ready_s;
    logic [1:0]  in_mode_s;
    logic        in_legal_s;
    logic [25:0] in_info_s;
    logic [31:0] cw_s;

    assign s2_ready_s = !s2_valid_r || out_ready;
    assign in_ready_s = !s1_valid_r || s2_ready_s;
    assign in_ready   = in_ready_s;
    assign out_valid  = s2_valid_r;
    assign data_out   = data_out_r;
    assign mode_err   = mode_err_r;
    assign cw_count   = cw_count_r;

    // Decode work_mod into a 2-bit mode plus legality and mask the info bits to K.
    always_comb begin
        in_mode_s  = 2'd0;
        in_legal_s = 1'b0;
        if (work_mod == AMBA_WORD'(32'd0)) begin
            in_mode_s  = 2'd0;
            in_legal_s = 1'b1;
        end else if (work_mod == AMBA_WORD'(32'd1)) begin
            in_mode_s  = 2'd1;
            in_legal_s = MODE1_OK;
        end else if (work_mod == AMBA_WORD'(32'd2)) begin
            in_mode_s  = 2'd2;
            in_legal_s = MODE2_OK;
        end else begin
            in_mode_s  = 2'd3;
            in_legal_s = 1'b0;
        end
        in_info_s = 26'(data_in) & info_mask(in_mode_s);
    end

    // Stage 1: capture masked info, mode and parity on each input handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_info_r  <= 26'd0;
            s1_mode_r  <= 2'd0;
            s1_legal_r <= 1'b0;
            s1_ham_r   <= 5'd0;
            s1_ovp_r   <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_info_r  <= in_info_s;
                s1_mode_r  <= in_mode_s;
                s1_legal_r <= in_legal_s;
                s1_ham_r   <= ham_bits(in_info_s);
                s1_ovp_r   <= ^in_info_s;
            end else begin
                s1_info_r  <= s1_info_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Codeword assembly: {zeros, info[K-1:0], overall parity, hamming[P-2:0]}.
    always_comb begin
        cw_s = 32'd0;
        if (s1_legal_r) begin
            case (s1_mode_r)
                2'd0:    cw_s = {24'd0, s1_info_r[3:0], s1_ovp_r, s1_ham_r[2:0]};
                2'd1:    cw_s = {16'd0, s1_info_r[10:0], s1_ovp_r, s1_ham_r[3:0]};
                2'd2:    cw_s = {s1_info_r[25:0], s1_ovp_r, s1_ham_r[4:0]};
                default: cw_s = 32'd0;
            endcase
        end else begin
            cw_s = 32'd0;
        end
    end

    // Stage 2: output register, advances whenever it is empty or being drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            data_out_r <= '0;
            mode_err_r <= 1'b0;
        end else if (s2_ready_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                data_out_r <= cw_s[MAX_CODEWORD_WIDTH-1:0];
                mode_err_r <= !s1_legal_r;
            end else begin
                data_out_r <= data_out_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Delivered-codeword counter, wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cw_count_r <= '0;
        end else if (s2_valid_r && out_ready) begin
            cw_count_r <= cw_count_r + CNT_WIDTH'(1);
        end else begin
            cw_count_r <= cw_count_r;
        end
    end

endmodule

// File: tb/tb_enc_hamming_pipe.sv
// Directed bench for enc_hamming_pipe: table of hand-computed codewords plus
// backpressure streaming and mid-flight reset sequences.
module tb_enc_hamming_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] data_in;
    logic [31:0] work_mod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        mode_err;
    logic [15:0] cw_count;

    enc_hamming_pipe #(
        .AMBA_WORD(32), .MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .work_mod(work_mod), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .mode_err(mode_err),
        .cw_count(cw_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mode;
        logic [25:0] data;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vec[14];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Single word on an empty pipe: checks acceptance, exact 2-clk latency, payload and count.
    task automatic send_one(input int idx);
        in_valid  = 1'b1;
        data_in   = vec[idx].data;
        work_mod  = vec[idx].mode;
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_lat1_valid", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d_lat2_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d_data", idx), 64'(data_out), 64'(vec[idx].exp_out));
        chk($sformatf("v%0d_err", idx), 64'(mode_err), 64'(vec[idx].exp_err));
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk($sformatf("v%0d_count", idx), 64'(cw_count), 64'(exp_cnt));
        @(negedge clk);
        chk($sformatf("v%0d_drained", idx), 64'(out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    // Eight words back to back with out_ready cycling 1,0,0,1.
    task automatic run_stream();
        int   exp_q[$];
        int   got;
        logic pat[4];
        logic prev_stall;
        logic [31:0] prev_data;
        logic prev_err;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        got = 0;
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        prev_err   = 1'b0;
        out_ready  = pat[0];
        fork
            begin
                for (int w = 0; w < 8; w++) begin
                    logic hs;
                    int   waits;
                    in_valid = 1'b1;
                    data_in  = vec[w].data;
                    work_mod = vec[w].mode;
                    exp_q.push_back(w);
                    waits = 0;
                    do begin
                        @(negedge clk);
                        hs = in_ready;
                        @(posedge clk); #1;
                        waits++;
                    end while (!hs && waits < 50);
                    if (!hs) chk("stream_accept_timeout", 64'd0, 64'd1);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    out_ready = pat[c % 4];
                    @(negedge clk);
                    if (prev_stall) begin
                        chk("stall_valid", 64'(out_valid), 64'd1);
                        chk("stall_data", 64'(data_out), 64'(prev_data));
                        chk("stall_err", 64'(mode_err), 64'(prev_err));
                    end
                    if (!in_ready) begin
                        chk("in_ready_low_cause", 64'(out_valid && !out_ready), 64'd1);
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("stream_extra_word", 64'd1, 64'd0);
                        end else begin
                            int w;
                            w = exp_q.pop_front();
                            chk($sformatf("stream%0d_data", got), 64'(data_out), 64'(vec[w].exp_out));
                            chk($sformatf("stream%0d_err", got), 64'(mode_err), 64'(vec[w].exp_err));
                            got++;
                            exp_cnt = exp_cnt + 16'd1;
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_data  = data_out;
                    prev_err   = mode_err;
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        chk("stream_word_count", 64'(got), 64'd8);
        chk("stream_cw_count", 64'(cw_count), 64'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{32'd0,         26'h000_000B, 32'h0000_00B9, 1'b0};
        vec[1]  = '{32'd1,         26'h000_0001, 32'h0000_0033, 1'b0};
        vec[2]  = '{32'd2,         26'h3FF_FFFF, 32'hFFFF_FFDF, 1'b0};
        vec[3]  = '{32'd3,         26'h000_0005, 32'h0000_0000, 1'b1};
        vec[4]  = '{32'd0,         26'h000_0000, 32'h0000_0000, 1'b0};
        vec[5]  = '{32'd0,         26'h000_000F, 32'h0000_00F7, 1'b0};
        vec[6]  = '{32'd0,         26'h3FF_FFF1, 32'h0000_001B, 1'b0};
        vec[7]  = '{32'd1,         26'h000_07FF, 32'h0000_FFFF, 1'b0};
        vec[8]  = '{32'd1,         26'h000_0400, 32'h0000_801F, 1'b0};
        vec[9]  = '{32'd2,         26'h000_0001, 32'h0000_0063, 1'b0};
        vec[10] = '{32'd2,         26'h200_0000, 32'h8000_003F, 1'b0};
        vec[11] = '{32'hFFFF_FFFF, 26'h3FF_FFFF, 32'h0000_0000, 1'b1};
        vec[12] = '{32'h0000_0100, 26'h000_0001, 32'h0000_0000, 1'b1};
        vec[13] = '{32'd1,         26'h3FF_F800, 32'h0000_0000, 1'b0};

        rst       = 1'b0;
        in_valid  = 1'b0;
        data_in   = 26'd0;
        work_mod  = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_data_out", 64'(data_out), 64'd0);
        chk("reset_mode_err", 64'(mode_err), 64'd0);
        chk("reset_cw_count", 64'(cw_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            send_one(i);
        end

        run_stream();
        repeat (2) @(posedge clk);
        #1;

        // Fill both stages with downstream stalled, then reset mid-flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = vec[5].data;
        work_mod  = vec[5].mode;
        @(posedge clk); #1;
        data_in   = vec[7].data;
        work_mod  = vec[7].mode;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head_data", 64'(data_out), 64'(vec[5].exp_out));
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_cw_count", 64'(cw_count), 64'd0);
        chk("midreset_data_out", 64'(data_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 16'd0;
        @(posedge clk); #1;
        chk("post_reset_no_replay", 64'(out_valid), 64'd0);
        send_one(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
